// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: load funct3 codes,
// the commit-queue entry layout and the pointer-width helper.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic        done;
    } entry_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half of an aligned load word and sign- or
// zero-extends it according to funct3.
module load_extender
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        data = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = word;
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// In-order write-back stage: a small commit queue of ALU results and loads,
// filled by in-order memory responses and retired one register write per cycle.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_data_i,
    input  logic        ex_is_load_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [1:0]  ex_addr_lo_i,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    output logic        reg_write_wb_o,
    output logic [4:0]  reg_rd_wb_o,
    output logic [31:0] reg_rd_data_wb_o,
    output logic        stall_writeback_o,
    output logic        protocol_err_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t queue [DEPTH];

    logic [PTR_W-1:0] head_reg, tail_reg, fill_reg, fill_next;
    logic [PTR_W:0]   count_reg, load_cnt_reg;
    logic             err_reg;
    logic             we_reg;
    logic [4:0]       rd_reg;
    logic [31:0]      data_reg;

    logic             full, empty, enq, bypass, store, fill, retire;
    logic             fill_found;
    logic [PTR_W-1:0] fill_scan, scan_idx;
    logic [PTR_W-1:0] slot_off [DEPTH];
    logic [DEPTH-1:0] waiting;
    entry_t           head_entry;
    logic [31:0]      ext_data, retire_data;

    assign full   = (count_reg == FULL_CNT);
    assign empty  = (count_reg == '0);
    assign enq    = ex_valid_i && !full;
    assign bypass = enq && empty && !ex_is_load_i;
    assign store  = enq && !bypass;
    assign fill   = mem_rsp_valid_i && (load_cnt_reg != '0);

    assign head_entry = queue[head_reg];
    // Only the registered done bit counts, so a load retires the edge after its fill.
    assign retire     = !empty && head_entry.done;

    // A slot is waiting when it is occupied and still has no memory data.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_off[gi] = PTR_W'(gi) - head_reg;
            assign waiting[gi]  = ({1'b0, slot_off[gi]} < count_reg) && !queue[gi].done;
        end
    endgenerate

    // Nearest waiting slot after the current fill pointer, in program order.
    always_comb begin
        fill_found = 1'b0;
        fill_scan  = tail_reg;
        scan_idx   = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            scan_idx = fill_reg + PTR_W'(k);
            if (waiting[scan_idx]) begin
                fill_found = 1'b1;
                fill_scan  = scan_idx;
            end
        end
    end

    always_comb begin
        fill_next = fill_reg;
        if (fill) begin
            fill_next = fill_found ? fill_scan : tail_reg;
        end else if (store && ex_is_load_i && (load_cnt_reg == '0)) begin
            fill_next = tail_reg;
        end
    end

    load_extender u_load_extender (
        .funct3  (head_entry.funct3),
        .addr_lo (head_entry.addr_lo),
        .word    (head_entry.data),
        .data    (ext_data)
    );

    assign retire_data = head_entry.is_load ? ext_data : head_entry.data;

    always_ff @(posedge clk_i) begin
        if (store) begin
            queue[tail_reg] <= '{rd:      ex_rd_i,
                                 data:    ex_data_i,
                                 is_load: ex_is_load_i,
                                 funct3:  ex_funct3_i,
                                 addr_lo: ex_addr_lo_i,
                                 done:    !ex_is_load_i};
        end
        if (fill) begin
            queue[fill_reg].data <= mem_rsp_data_i;
            queue[fill_reg].done <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            fill_reg     <= '0;
            count_reg    <= '0;
            load_cnt_reg <= '0;
            err_reg      <= 1'b0;
            we_reg       <= 1'b0;
            rd_reg       <= '0;
            data_reg     <= '0;
        end else begin
            if (store) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (retire) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            fill_reg     <= fill_next;
            count_reg    <= count_reg + (PTR_W + 1)'(store) - (PTR_W + 1)'(retire);
            load_cnt_reg <= load_cnt_reg + (PTR_W + 1)'(store && ex_is_load_i)
                                         - (PTR_W + 1)'(fill);
            err_reg      <= err_reg || (ex_valid_i && full)
                                    || (mem_rsp_valid_i && (load_cnt_reg == '0));
            if (bypass) begin
                we_reg   <= (ex_rd_i != 5'd0);
                rd_reg   <= ex_rd_i;
                data_reg <= ex_data_i;
            end else if (retire) begin
                we_reg   <= (head_entry.rd != 5'd0);
                rd_reg   <= head_entry.rd;
                data_reg <= retire_data;
            end else begin
                we_reg   <= 1'b0;
            end
        end
    end

    assign reg_write_wb_o    = we_reg;
    assign reg_rd_wb_o       = rd_reg;
    assign reg_rd_data_wb_o  = data_reg;
    assign stall_writeback_o = full;
    assign protocol_err_o    = err_reg;

endmodule
